// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and anode helper for the seven-segment scan driver
package sseg_pkg;

    localparam int HEX_W = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] AN_ALL_OFF = 8'hFF;
    localparam logic                  DP_OFF     = 1'b1;

    // Low-active one-hot anode pattern; bits at or above n stay off.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_n(input int idx, input int n);
        logic [MAX_DIGITS-1:0] pattern;
        pattern = AN_ALL_OFF;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n && i == idx) begin
                pattern[i] = 1'b0;
            end
        end
        return pattern;
    endfunction

endpackage

// File: rtl/sseg_scan_mux_if.sv
// rtl/sseg_scan_mux_if.sv - load/value inputs and display outputs of the scan driver
interface sseg_scan_mux_if
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 4
);
    localparam int IDX_W = (N_DIGITS <= 2) ? 1 : $clog2(N_DIGITS);

    logic                      load;
    logic [HEX_W*N_DIGITS-1:0] value_in;
    logic [N_DIGITS-1:0]       dp_in;
    logic [N_DIGITS-1:0]       blank_in;

    logic [HEX_W-1:0]          hex_digit;
    logic                      dp_n;
    logic [N_DIGITS-1:0]       an_n;
    logic [IDX_W-1:0]          digit_idx;
    logic                      frame_start;
    logic                      update_ack;

    modport master (
        output load, value_in, dp_in, blank_in,
        input  hex_digit, dp_n, an_n, digit_idx, frame_start, update_ack
    );

    modport slave (
        input  load, value_in, dp_in, blank_in,
        output hex_digit, dp_n, an_n, digit_idx, frame_start, update_ack
    );

endinterface

// File: rtl/sseg_refresh_prescaler.sv
// rtl/sseg_refresh_prescaler.sv - divides clk into one tick per digit slot
module sseg_refresh_prescaler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CNT_W = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - frame-synchronised seven-segment digit scanner
// Define SSEG_LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic          clk,
    input  logic          reset_n,
    sseg_scan_mux_if.slave bus
);
    localparam int IDX_W = (N_DIGITS <= 2) ? 1 : $clog2(N_DIGITS);
    localparam int VAL_W = HEX_W * N_DIGITS;

    logic tick;

    sseg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic                pending_q,    pending_d;
    logic [VAL_W-1:0]    pend_val_q,   pend_val_d;
    logic [N_DIGITS-1:0] pend_dp_q,    pend_dp_d;
    logic [N_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic [VAL_W-1:0]    sh_val_q,     sh_val_d;
    logic [N_DIGITS-1:0] sh_dp_q,      sh_dp_d;
    logic [N_DIGITS-1:0] sh_blank_q,   sh_blank_d;

    logic [HEX_W-1:0]    hex_q,         hex_d;
    logic                dp_n_q,        dp_n_d;
    logic [N_DIGITS-1:0] an_n_q,        an_n_d;
    logic [IDX_W-1:0]    digit_idx_q,   digit_idx_d;
    logic                frame_start_q, frame_start_d;
    logic                update_ack_q,  update_ack_d;

    logic                boundary;
    logic                take;
    logic [VAL_W-1:0]    src_val;
    logic [N_DIGITS-1:0] src_dp;
    logic [N_DIGITS-1:0] src_blank;
    logic [N_DIGITS-1:0] auto_blank;
    logic [MAX_DIGITS-1:0] an_pattern;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // Digit k>0 goes dark when it and every digit above it are zero.
    function automatic logic [N_DIGITS-1:0] lead_zero_mask(input logic [VAL_W-1:0] v);
        logic all_zero;
        lead_zero_mask = '0;
        all_zero       = 1'b1;
        for (int k = N_DIGITS - 1; k > 0; k--) begin
            all_zero          = all_zero && (v[HEX_W*k +: HEX_W] == '0);
            lead_zero_mask[k] = all_zero;
        end
    endfunction

    always_comb begin
        auto_blank = lead_zero_mask(src_val);
    end
`else
    always_comb begin
        auto_blank = '0;
    end
`endif

    always_comb begin
        boundary = tick && (idx_q == IDX_W'(N_DIGITS - 1));
        idx_d    = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        pending_d    = pending_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        if (bus.load) begin
            pending_d    = 1'b1;
            pend_val_d   = bus.value_in;
            pend_dp_d    = bus.dp_in;
            pend_blank_d = bus.blank_in;
        end

        // A load coinciding with the boundary bypasses the pending stage.
        take      = boundary && (pending_q || bus.load);
        src_val   = bus.load ? bus.value_in : pend_val_q;
        src_dp    = bus.load ? bus.dp_in    : pend_dp_q;
        src_blank = bus.load ? bus.blank_in : pend_blank_q;
        if (boundary) begin
            pending_d = 1'b0;
        end

        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        if (take) begin
            sh_val_d   = src_val;
            sh_dp_d    = src_dp & ~auto_blank;
            sh_blank_d = src_blank | auto_blank;
        end
    end

    always_comb begin
        an_pattern  = an_onehot_n(32'(idx_q), N_DIGITS);
        hex_d       = sh_val_q[HEX_W*32'(idx_q) +: HEX_W];
        digit_idx_d = idx_q;
        if (sh_blank_q[idx_q]) begin
            an_n_d = AN_ALL_OFF[N_DIGITS-1:0];
            dp_n_d = DP_OFF;
        end else begin
            an_n_d = an_pattern[N_DIGITS-1:0];
            dp_n_d = ~sh_dp_q[idx_q];
        end
        // Outputs move to idx 0 from a nonzero digit only on a real wrap.
        frame_start_d = (idx_q == '0) && (digit_idx_q != '0);
        update_ack_d  = take;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q         <= '0;
            pending_q     <= 1'b0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            sh_val_q      <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '1;
            hex_q         <= '0;
            dp_n_q        <= DP_OFF;
            an_n_q        <= AN_ALL_OFF[N_DIGITS-1:0];
            digit_idx_q   <= '0;
            frame_start_q <= 1'b0;
            update_ack_q  <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            sh_val_q      <= sh_val_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            hex_q         <= hex_d;
            dp_n_q        <= dp_n_d;
            an_n_q        <= an_n_d;
            digit_idx_q   <= digit_idx_d;
            frame_start_q <= frame_start_d;
            update_ack_q  <= update_ack_d;
        end
    end

    assign bus.hex_digit   = hex_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.an_n        = an_n_q;
    assign bus.digit_idx   = digit_idx_q;
    assign bus.frame_start = frame_start_q;
    assign bus.update_ack  = update_ack_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - randomized model-checked bench for sseg_scan_mux (N=4, DIV=4)
module tb_sseg_scan_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset_n;

    sseg_scan_mux_if #(.N_DIGITS(N)) bus ();

    sseg_scan_mux #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot position from elapsed cycles, shadow as plain arrays.
    int          m_cyc;
    logic        m_pend;
    logic [15:0] m_pv;
    logic [3:0]  m_pd, m_pb;
    logic [15:0] m_sv;
    logic [3:0]  m_sd, m_sb;
    logic [3:0]  m_auto;
    int          dig, pdig;
    logic        bnd;
    logic        chk_en = 1'b0;
    logic [3:0]  e_hex;
    logic        e_dp;
    logic [3:0]  e_an;
    logic [1:0]  e_idx;
    logic        e_fs, e_ack;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_cyc = 0; m_pend = 0;
            m_pv = 0; m_pd = 0; m_pb = 4'hF;
            m_sv = 0; m_sd = 0; m_sb = 4'hF;
            e_hex = 0; e_dp = 1; e_an = 4'hF; e_idx = 0; e_fs = 0; e_ack = 0;
            chk_en = 1'b1;
        end else begin
            dig   = (m_cyc / DIV) % N;
            pdig  = (m_cyc > 0) ? ((m_cyc - 1) / DIV) % N : 0;
            e_hex = 4'((m_sv >> (4 * dig)) & 16'hF);
            e_idx = 2'(dig);
            e_an  = m_sb[dig] ? 4'hF : ~(4'b0001 << dig);
            e_dp  = m_sb[dig] ? 1'b1 : ~m_sd[dig];
            e_fs  = (m_cyc > 0) && (dig == 0) && (pdig == N - 1);
            bnd   = (m_cyc % DIV == DIV - 1) && (dig == N - 1);
            if (bus.load) begin
                m_pend = 1; m_pv = bus.value_in; m_pd = bus.dp_in; m_pb = bus.blank_in;
            end
            e_ack = bnd && m_pend;
            if (bnd && m_pend) begin
                m_auto = 4'b0000;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
                for (int k = 1; k < N; k++) m_auto[k] = ((m_pv >> (4 * k)) == 16'h0);
`endif
                m_sv = m_pv;
                m_sd = m_pd & ~m_auto;
                m_sb = m_pb | m_auto;
            end
            if (bnd) m_pend = 0;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (bus.hex_digit !== e_hex || bus.dp_n !== e_dp || bus.an_n !== e_an ||
                bus.digit_idx !== e_idx || bus.frame_start !== e_fs || bus.update_ack !== e_ack) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got hex=%h dp_n=%b an_n=%b idx=%0d fs=%b ack=%b, want hex=%h dp_n=%b an_n=%b idx=%0d fs=%b ack=%b",
                         $time, bus.hex_digit, bus.dp_n, bus.an_n, bus.digit_idx, bus.frame_start, bus.update_ack,
                         e_hex, e_dp, e_an, e_idx, e_fs, e_ack);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n, output int acks, output int fss);
        acks = 0; fss = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.update_ack) acks++;
            if (bus.frame_start) fss++;
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        @(negedge clk);
        while (bus.frame_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("wait_frame_start_timeout", 0, 1);
    endtask

    task automatic wait_digit(input int k);
        int n = 0;
        while (bus.digit_idx !== 2'(k) && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("wait_digit_timeout", 0, 1);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.load = 1; bus.value_in = v; bus.dp_in = d; bus.blank_in = b;
        @(negedge clk);
        bus.load = 0;
    endtask

    task automatic check_digit(input int k, input logic [3:0] hex, input logic [3:0] an, input logic dp);
        wait_digit(k);
        if (an != 4'hF) check($sformatf("hex_d%0d", k), 32'(bus.hex_digit), 32'(hex));
        check($sformatf("an_d%0d", k), 32'(bus.an_n), 32'(an));
        check($sformatf("dp_d%0d", k), 32'(bus.dp_n), 32'(dp));
    endtask

    int acks, fss;

    initial begin
        reset_n = 0; bus.load = 0; bus.value_in = 0; bus.dp_in = 0; bus.blank_in = 0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(bus.an_n), 32'hF);
        check("rst_dp", 32'(bus.dp_n), 1);
        check("rst_hex", 32'(bus.hex_digit), 0);
        check("rst_idx", 32'(bus.digit_idx), 0);
        check("rst_fs_ack", 32'({bus.frame_start, bus.update_ack}), 0);
        reset_n = 1;

        // Idle: dark display, one frame_start per 16 clocks.
        wait_fs();
        run_cycles(64, acks, fss);
        check("idle_fs_count", 32'(fss), 4);
        check("idle_ack_count", 32'(acks), 0);

        // Mid-frame load.
        wait_fs();
        repeat (5) @(negedge clk);
        pulse_load(16'h12A4, 4'b0010, 4'b0000);
        run_cycles(20, acks, fss);
        check("load1_acks", 32'(acks), 1);
        wait_fs();
        check_digit(0, 4'h4, 4'b1110, 1'b1);
        check_digit(1, 4'hA, 4'b1101, 1'b0);
        check_digit(2, 4'h2, 4'b1011, 1'b1);
        check_digit(3, 4'h1, 4'b0111, 1'b1);

        // Two loads in one frame: last wins.
        wait_fs();
        repeat (2) @(negedge clk);
        pulse_load(16'h1111, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        pulse_load(16'h2222, 4'b0000, 4'b0000);
        run_cycles(20, acks, fss);
        check("twoload_acks", 32'(acks), 1);
        wait_fs();
        check_digit(2, 4'h2, 4'b1011, 1'b1);

        // Load exactly on the boundary cycle (two cycles before frame_start).
        wait_fs();
        repeat (14) @(negedge clk);
        pulse_load(16'h0F0F, 4'b0000, 4'b0000);
        check("bypass_ack_now", 32'(bus.update_ack), 1);
        run_cycles(32, acks, fss);
        check("bypass_no_second_ack", 32'(acks), 0);
        wait_fs();
        check_digit(0, 4'hF, 4'b1110, 1'b1);
        check_digit(1, 4'h0, 4'b1101, 1'b1);

        // Per-digit blank request.
        wait_fs();
        pulse_load(16'h5678, 4'b0100, 4'b0100);
        run_cycles(20, acks, fss);
        wait_fs();
        check_digit(2, 4'h6, 4'b1111, 1'b1);
        check_digit(3, 4'h5, 4'b0111, 1'b1);

        // Reset mid-frame with pending data.
        wait_fs();
        repeat (3) @(negedge clk);
        pulse_load(16'h9999, 4'b1111, 4'b0000);
        reset_n = 0;
        @(negedge clk);
        check("midrst_an", 32'(bus.an_n), 32'hF);
        check("midrst_dp", 32'(bus.dp_n), 1);
        check("midrst_idx_hex", 32'({bus.digit_idx, bus.hex_digit}), 0);
        reset_n = 1;
        run_cycles(40, acks, fss);
        check("midrst_no_ack", 32'(acks), 0);

        pulse_load(16'h0030, 4'b0000, 4'b0000);
        run_cycles(20, acks, fss);
        wait_fs();
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        check_digit(0, 4'h0, 4'b1110, 1'b1);
        check_digit(1, 4'h3, 4'b1101, 1'b1);
        check_digit(2, 4'h0, 4'b1111, 1'b1);
        check_digit(3, 4'h0, 4'b1111, 1'b1);
        pulse_load(16'h0000, 4'b1111, 4'b0000);
        run_cycles(20, acks, fss);
        wait_fs();
        check_digit(0, 4'h0, 4'b1110, 1'b0);
        check_digit(1, 4'h0, 4'b1111, 1'b1);
`else
        check_digit(1, 4'h3, 4'b1101, 1'b1);
        check_digit(3, 4'h0, 4'b0111, 1'b1);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.value_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.value_in[15:8] = 8'h00;
            bus.dp_in    = 4'($urandom);
            bus.blank_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            reset_n      = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        bus.load = 0; reset_n = 1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
- Time-multiplexed scan driver for an N-digit common-anode seven-segment display; sits directly upstream of the hex-to-segment decoder.
- Holds a frame-synchronised shadow copy of the displayed value and selects one digit per refresh slot.
- Drives the decoder's 4-bit hex input and low-active dp input, plus the low-active digit anode enables.
- Display updates are applied only at frame boundaries, so a digit never shows a mix of old and new values.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal range 2..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 1 (1 means a new slot every cycle).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- load  in  1  single-cycle strobe; capture value_in/dp_in/blank_in.
- value_in  in  4*N_DIGITS  hex digits; digit k = value_in[4k+3:4k], digit 0 rightmost.
- dp_in  in  N_DIGITS  decimal point request per digit, active-high.
- blank_in  in  N_DIGITS  per-digit blank request, active-high.
- hex_digit  out  4  to decoder hex input.
- dp_n  out  1  to decoder dp input; low = point lit.
- an_n  out  N_DIGITS  anode enables, low-active, at most one low at any time.
- digit_idx  out  clog2(N_DIGITS)  index of the digit currently driven.
- frame_start  out  1  one-cycle pulse when digit 0 becomes active.
- update_ack  out  1  one-cycle pulse when the shadow register takes pending data.

Behaviour:
- Reset (reset_n low at clk edge):
  - prescaler=0, idx=0, pending flag=0.
  - Shadow and pending value/dp = 0; shadow and pending blank = all ones.
  - an_n = all ones, hex_digit=0, dp_n=1, digit_idx=0, frame_start=0, update_ack=0.
  - Reset mid-frame discards pending data; no update_ack is issued.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick asserts in the cycle where count == REFRESH_DIV-1.
- Digit index:
  - On tick, idx increments; it wraps from N_DIGITS-1 to 0.
  - The frame boundary is a tick with idx == N_DIGITS-1.
- Load path:
  - load=1 copies the inputs into the pending registers and sets pending.
  - Repeated loads before a boundary overwrite pending (last wins).
- Shadow update:
  - At a boundary with pending set, the shadow takes the pending registers, pending clears, and update_ack pulses in the next cycle.
  - If load and the boundary coincide, that cycle's inputs go straight to the shadow (bypass), the pending flag ends cleared, and update_ack pulses.
  - A boundary without pending leaves the shadow unchanged and raises no ack.
- Outputs, registered, one-cycle latency from the idx update (they reflect the new digit in the cycle after the tick's effect on idx):
  - hex_digit = shadow nibble[idx].
  - dp_n = ~shadow_dp[idx].
  - an_n = all ones except bit idx low; if shadow_blank[idx]=1, an_n = all ones and dp_n=1.
  - digit_idx = idx.
  - frame_start=1 for the one cycle in which the outputs first show idx 0 of a new frame; not asserted for the post-reset first frame.
- First frame after reset: an_n stays all ones until the first output register update. The shadow is all-blank after reset, so the display stays dark until the first applied load.
- Widths: idx width = max(1, clog2(N_DIGITS)); no arithmetic on the value.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined: in addition to blank_in, a digit k > 0 is blanked when it and all digits above it are 0 in the shadow. Digit 0 is never auto-blanked.
- Auto-blanking is computed once, when the shadow is loaded, and stored in the shadow blank register.
- dp_in on an auto-blanked digit is suppressed.
- Undefined: zeros are displayed; only blank_in blanks.

Decomposition:
- Package sseg_pkg holds:
  - HEX_W = 4.
  - Function an_onehot_n(idx, n).
  - Constants AN_ALL_OFF and DP_OFF (= 1'b1).
- One sub-module: sseg_refresh_prescaler (parameter REFRESH_DIV; ports clk, reset_n, tick).
- Shadow, pending, index and output registers stay in sseg_scan_mux.

Test Plan (N_DIGITS=4, REFRESH_DIV=4):
- Reset, no load -> an_n=4'b1111 and dp_n=1 forever; digit_idx cycles 0,1,2,3 every 4 clocks; frame_start pulses every 16 clocks after the first frame.
- Load 16'h12A4, dp_in=4'b0010, blank_in=0 mid-frame:
  - Display stays dark until the boundary; update_ack pulses once.
  - Then for idx 0..3: hex_digit = 4,A,2,1; an_n = 1110,1101,1011,0111; dp_n=0 only at idx 1.
- Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is ever shown; one update_ack.
- Load asserted exactly on the boundary cycle with 16'h0F0F -> shown starting from the next frame's idx 0; update_ack pulses; pending is not left set (no second ack at the following boundary).
- blank_in=4'b0100 with 16'h5678 -> at idx 2, an_n=1111 and dp_n=1; other digits normal.
- Reset asserted mid-frame with pending data -> next cycle all outputs at reset values; no ack.
- With SSEG_LEADING_ZERO_BLANK_EN, load 16'h0030:
  - idx 3 and idx 2 dark; idx 1 shows 3; idx 0 shows 0.
  - Load 16'h0000 -> only idx 0 lit, showing 0.
